// File: rtl/datapath_mc.sv
// Multi-cycle RV32I datapath: FETCH/EXEC/MEM/TRAP sequencer around decoder, ALU, regfile and CSRs,
// with valid/ready memory handshakes, a wait-cycle timeout trap and a per-instruction retire pulse.
module datapath_mc #(
  parameter bit          ENABLE_COUNTERS = 1'b1,
  parameter logic [31:0] RESET_PC        = 32'h0000_0200,
  parameter int          MEM_TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        retire,
  output logic        error
);
  localparam logic [1:0]  S_FETCH = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2, S_TRAP = 2'd3;
  localparam logic [31:0] RV_NOP = 32'h0000_0013, RV_INVALID = 32'h0000_0000;
  localparam logic [6:0]  OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                          OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                          OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;
  localparam int          CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_TIMEOUT);

  logic [1:0]    state_reg, state_next;
  logic [31:0]   pc_reg, inst_reg, pc_next, pc_plus4;
  logic [CW-1:0] wait_reg;
  logic          fetch_armed_reg, waiting, timeout_hit;
  logic [31:0]   regs [0:31];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val;
  logic [31:0] alu_b, alu_out, exec_wb, load_data, ld_shift, wb_data, csr_rdata, csr_src, csr_wval;
  logic [3:0][7:0] store_lane;
  logic        illegal, is_load, is_store, is_mem, is_csr, rd_we, br_taken, alu_sub, alu_sra;
  logic        commit_exec, mem_done, reg_we;
  logic [1:0]  csr_cmd;
  logic [2:0]  alu_f3;

  assign opcode = inst_reg[6:0];
  assign rd     = inst_reg[11:7];
  assign f3     = inst_reg[14:12];
  assign rs1    = inst_reg[19:15];
  assign rs2    = inst_reg[24:20];
  assign f7     = inst_reg[31:25];
  assign imm_i  = {{20{inst_reg[31]}}, inst_reg[31:20]};
  assign imm_s  = {{20{inst_reg[31]}}, inst_reg[31:25], inst_reg[11:7]};
  assign imm_b  = {{19{inst_reg[31]}}, inst_reg[31], inst_reg[7], inst_reg[30:25], inst_reg[11:8], 1'b0};
  assign imm_u  = {inst_reg[31:12], 12'h000};
  assign imm_j  = {{11{inst_reg[31]}}, inst_reg[31], inst_reg[19:12], inst_reg[20], inst_reg[30:21], 1'b0};

  // x0 is forced to zero on read, so the array itself never needs a reset
  assign rs1_val  = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'h0 : regs[rs2];
  assign pc_plus4 = pc_reg + 32'd4;

  assign alu_b   = (opcode == OP_REG) ? rs2_val : (opcode == OP_STORE) ? imm_s : imm_i;
  assign alu_f3  = (opcode == OP_REG || opcode == OP_IMM) ? f3 : 3'b000;
  assign alu_sub = (opcode == OP_REG) && inst_reg[30];
  assign alu_sra = inst_reg[30];

  always_comb begin
    case (alu_f3)
      3'b000:  alu_out = alu_sub ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001:  alu_out = rs1_val << alu_b[4:0];
      3'b010:  alu_out = {31'h0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_out = {31'h0, rs1_val < alu_b};
      3'b100:  alu_out = rs1_val ^ alu_b;
      3'b101:  alu_out = alu_sra ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
      3'b110:  alu_out = rs1_val | alu_b;
      default: alu_out = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    case (f3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = $signed(rs1_val) < $signed(rs2_val);
      3'b101:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  br_taken = rs1_val < rs2_val;
      3'b111:  br_taken = rs1_val >= rs2_val;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    illegal  = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_csr   = 1'b0;
    rd_we    = 1'b0;
    exec_wb  = alu_out;
    pc_next  = pc_plus4;
    case (opcode)
      OP_LUI:    begin rd_we = 1'b1; exec_wb = imm_u; end
      OP_AUIPC:  begin rd_we = 1'b1; exec_wb = pc_reg + imm_u; end
      OP_JAL:    begin rd_we = 1'b1; exec_wb = pc_plus4; pc_next = pc_reg + imm_j; end
      OP_JALR: begin
        illegal = (f3 != 3'b000);
        rd_we   = 1'b1;
        exec_wb = pc_plus4;
        pc_next = (rs1_val + imm_i) & ~32'd1;
      end
      OP_BRANCH: begin
        illegal = (f3 == 3'b010) || (f3 == 3'b011);
        if (br_taken) pc_next = pc_reg + imm_b;
      end
      OP_LOAD:   begin illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11); is_load = 1'b1; end
      OP_STORE:  begin illegal = (f3 > 3'b010); is_store = 1'b1; end
      OP_IMM: begin
        illegal = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                  ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
        rd_we   = 1'b1;
      end
      OP_REG: begin
        illegal = (f7 != 7'h00) && !((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
        rd_we   = 1'b1;
      end
      OP_FENCE:  ;
      OP_SYSTEM: begin
        illegal = (f3 == 3'b100);
        is_csr  = (f3[1:0] != 2'b00);
        rd_we   = is_csr;
        exec_wb = csr_rdata;
      end
      default:   illegal = 1'b1;
    endcase
  end

  assign is_mem      = is_load || is_store;
  assign commit_exec = (state_reg == S_EXEC) && !illegal && !is_mem;
  assign mem_done    = (state_reg == S_MEM) && dmem_ready;
  assign retire      = commit_exec || mem_done;
  assign reg_we      = (commit_exec && rd_we) || (mem_done && is_load);

  assign ld_shift = dmem_rdata >> {alu_out[1:0], 3'b000};
  always_comb begin
    case (f3)
      3'b000:  load_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  load_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  load_data = {24'h0, ld_shift[7:0]};
      3'b101:  load_data = {16'h0, ld_shift[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end
  assign wb_data = (state_reg == S_MEM) ? load_data : exec_wb;

  for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
    assign store_lane[gi] =
      (f3[1:0] == 2'b00) ? ((alu_out[1:0] == 2'(gi)) ? rs2_val[7:0] : 8'h00) :
      (f3[1:0] == 2'b01) ? ((alu_out[1] == 1'(gi / 2)) ? rs2_val[(gi % 2)*8 +: 8] : 8'h00) :
      rs2_val[gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (reg_we && (rd != 5'd0)) regs[rd] <= wb_data;
  end

  assign csr_cmd = (commit_exec && is_csr) ? f3[1:0] : 2'b00;
  assign csr_src = f3[2] ? {27'h0, rs1} : rs1_val;
  always_comb begin
    case (csr_cmd)
      2'b01:   csr_wval = csr_src;
      2'b10:   csr_wval = csr_rdata | csr_src;
      2'b11:   csr_wval = csr_rdata & ~csr_src;
      default: csr_wval = csr_rdata;
    endcase
  end

  if (ENABLE_COUNTERS) begin : g_csr
    logic [31:0] mscratch_reg;
    logic [63:0] instret_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mscratch_reg <= 32'h0;
        instret_reg  <= 64'h0;
      end else begin
        if (retire) instret_reg <= instret_reg + 64'd1;
        if ((csr_cmd != 2'b00) && (inst_reg[31:20] == 12'h340)) mscratch_reg <= csr_wval;
      end
    end
    always_comb begin
      case (inst_reg[31:20])
        12'h340:          csr_rdata = mscratch_reg;
        12'hC02, 12'hB02: csr_rdata = instret_reg[31:0];
        12'hC82, 12'hB82: csr_rdata = instret_reg[63:32];
        default:          csr_rdata = 32'h0;
      endcase
    end
  end else begin : g_no_csr
    assign csr_rdata = 32'h0;
  end

  // Waiting cycles in FETCH/MEM run the timeout; a valid is only taken once the request has been up a cycle
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_reg == WAIT_LIMIT);
  always_comb begin
    state_next = state_reg;
    waiting    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (imem_valid && fetch_armed_reg) state_next = S_EXEC;
        else begin
          waiting = 1'b1;
          if (timeout_hit) state_next = S_TRAP;
        end
      end
      S_EXEC:  state_next = illegal ? S_TRAP : (is_mem ? S_MEM : S_FETCH);
      S_MEM: begin
        if (dmem_ready) state_next = S_FETCH;
        else begin
          waiting = 1'b1;
          if (timeout_hit) state_next = S_TRAP;
        end
      end
      default: state_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_FETCH;
      pc_reg          <= RESET_PC;
      inst_reg        <= RV_NOP;
      wait_reg        <= '0;
      fetch_armed_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      fetch_armed_reg <= (state_reg == S_FETCH) && (state_next == S_FETCH);
      if (state_next != state_reg) wait_reg <= '0;
      else if (waiting && (wait_reg != '1)) wait_reg <= wait_reg + 1'b1;
      if ((state_reg == S_FETCH) && (state_next == S_EXEC)) inst_reg <= imem_rdata;
      else if ((state_reg == S_EXEC) && illegal) inst_reg <= RV_INVALID;
      if (retire) pc_reg <= pc_next;
    end
  end

  assign imem_req   = (state_reg == S_FETCH) && !reset;
  assign imem_addr  = reset ? 32'h0 : pc_reg;
  assign dmem_req   = (state_reg == S_MEM);
  assign dmem_we    = dmem_req && is_store;
  assign dmem_addr  = dmem_req ? alu_out : 32'h0;
  assign dmem_wdata = dmem_req ? store_lane : 32'h0;
  assign error      = (state_reg == S_TRAP);
endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc: hand-encoded RV32I program driven through imem/dmem handshakes.
`timescale 1ns/1ps
module tb_datapath_mc;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_valid = 1'b0, dmem_req, dmem_we, dmem_ready = 1'b0, retire, error;
  logic [31:0] imem_addr, imem_rdata = 32'h0, dmem_addr, dmem_wdata, dmem_rdata = 32'h0;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] fetch_addr, mem_addr, mem_wdata;
  logic        mem_we, mem_retire;

  localparam logic [31:0] I_ADDI_X1_5   = 32'h0050_0093;
  localparam logic [31:0] I_LW_X2_0_X1  = 32'h0000_A103;
  localparam logic [31:0] I_SW_X2_0_X0  = 32'h0020_2023;
  localparam logic [31:0] I_ADDI_X3_AB  = 32'h0AB0_0193;
  localparam logic [31:0] I_SB_X3_1_X0  = 32'h0030_00A3;
  localparam logic [31:0] I_SW_X1_0_X0  = 32'h0010_2023;
  localparam logic [31:0] I_JAL_M8      = 32'hFF9F_F06F;
  localparam logic [31:0] I_BEQ_M8      = 32'hFE00_0CE3;
  localparam logic [31:0] I_JAL_P8      = 32'h0080_006F;
  localparam logic [31:0] I_BNE_M8      = 32'hFE00_1CE3;
  localparam logic [31:0] I_ILLEGAL     = 32'hFFFF_FFFF;

  datapath_mc #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .retire(retire), .error(error)
  );

  always #5 clk = ~clk;

  // Waits for a fetch request, answers it one cycle later; returns at the negedge of the EXEC cycle
  task automatic issue(input logic [31:0] ins);
    int n = 0;
    @(negedge clk);
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    fetch_addr = imem_addr;
    if (!imem_req) begin
      total_cnt++;
      $display("FAIL fetch_wait: imem_req never rose, got %0b want 1", imem_req);
    end
    $display("fetch  addr=%08h inst=%08h", fetch_addr, ins);
    @(negedge clk);
    imem_valid = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
  endtask

  // Completes a data request in its first cycle and records what the datapath presented
  task automatic do_mem(input logic [31:0] rdata);
    int n = 0;
    @(negedge clk);
    while (!dmem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!dmem_req) begin
      total_cnt++;
      $display("FAIL mem_wait: dmem_req never rose, got %0b want 1", dmem_req);
    end
    mem_we = dmem_we;
    mem_addr = dmem_addr;
    mem_wdata = dmem_wdata;
    dmem_ready = 1'b1;
    dmem_rdata = rdata;
    #1 mem_retire = retire;
    $display("mem    we=%0b addr=%08h wdata=%08h retire=%0b", mem_we, mem_addr, mem_wdata, mem_retire);
    @(negedge clk);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({imem_req, dmem_req, retire, error} !== 4'b0000)
      $display("FAIL reset_outputs: got req/dreq/ret/err=%04b want 0000", {imem_req, dmem_req, retire, error});
    else pass_cnt++;
    total_cnt++;
    if (imem_addr !== 32'h0) $display("FAIL reset_imem_addr: got %08h want 00000000", imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_first_fetch();
    reset = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = I_ILLEGAL;
    #1;
    total_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200)
      $display("FAIL first_req: got req=%0b addr=%08h want 1 00000200", imem_req, imem_addr);
    else pass_cnt++;
    @(negedge clk);
    imem_rdata = I_ADDI_X1_5;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    #1;
    total_cnt++;
    if (retire !== 1'b1 || error !== 1'b0)
      $display("FAIL addi_retire_cycle3: got retire=%0b error=%0b want 1 0", retire, error);
    else pass_cnt++;
  endtask

  task automatic test_load();
    int req_cnt = 0;
    int ret_cnt = 0;
    logic addr_bad = 1'b0;
    issue(I_LW_X2_0_X1);
    total_cnt++;
    if (fetch_addr !== 32'h204) $display("FAIL next_addr_after_addi: got %08h want 00000204", fetch_addr);
    else pass_cnt++;
    #1 ret_cnt += int'(retire);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) begin
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
      end
      #1;
      req_cnt += int'(dmem_req);
      ret_cnt += int'(retire);
      if (dmem_addr !== 32'h5 || dmem_we !== 1'b0) addr_bad = 1'b1;
    end
    @(negedge clk);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    #1 ret_cnt += int'(retire);
    $display("load   req_cycles=%0d retires=%0d", req_cnt, ret_cnt);
    total_cnt++;
    if (req_cnt != 4) $display("FAIL lw_req_held: got %0d cycles want 4", req_cnt);
    else pass_cnt++;
    total_cnt++;
    if (addr_bad) $display("FAIL lw_addr_stable: got unstable addr want 00000005 we=0");
    else pass_cnt++;
    total_cnt++;
    if (ret_cnt != 1) $display("FAIL lw_one_retire: got %0d want 1", ret_cnt);
    else pass_cnt++;
    issue(I_SW_X2_0_X0);
    do_mem(32'h0);
    total_cnt++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_retire !== 1'b1)
      $display("FAIL x2_readback: got we=%0b wdata=%08h ret=%0b want 1 deadbeef 1", mem_we, mem_wdata, mem_retire);
    else pass_cnt++;
  endtask

  task automatic test_store_byte();
    issue(I_ADDI_X3_AB);
    total_cnt++;
    if (fetch_addr !== 32'h20C) $display("FAIL addi_x3_addr: got %08h want 0000020c", fetch_addr);
    else pass_cnt++;
    issue(I_SB_X3_1_X0);
    do_mem(32'h0);
    total_cnt++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h1 || mem_wdata[15:8] !== 8'hAB)
      $display("FAIL sb_lane1: got we=%0b addr=%08h lane1=%02h want 1 00000001 ab", mem_we, mem_addr, mem_wdata[15:8]);
    else pass_cnt++;
    issue(I_SW_X1_0_X0);
    do_mem(32'h0);
    total_cnt++;
    if (mem_wdata !== 32'h5 || fetch_addr !== 32'h214)
      $display("FAIL x1_unchanged: got wdata=%08h addr=%08h want 00000005 00000214", mem_wdata, fetch_addr);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    issue(I_JAL_M8);
    issue(I_BEQ_M8);
    total_cnt++;
    if (fetch_addr !== 32'h210) $display("FAIL jal_target: got %08h want 00000210", fetch_addr);
    else pass_cnt++;
    issue(I_JAL_P8);
    total_cnt++;
    if (fetch_addr !== 32'h208) $display("FAIL beq_taken: got %08h want 00000208", fetch_addr);
    else pass_cnt++;
    issue(I_BNE_M8);
    total_cnt++;
    if (fetch_addr !== 32'h210) $display("FAIL jal_fwd_target: got %08h want 00000210", fetch_addr);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int req_cnt = 0;
    int ret_cnt = 0;
    logic [31:0] first_addr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (i == 0) first_addr = imem_addr;
      req_cnt += int'(imem_req);
      ret_cnt += int'(retire) + int'(dmem_req);
    end
    $display("tmo    first_addr=%08h req_cycles=%0d error=%0b", first_addr, req_cnt, error);
    total_cnt++;
    if (first_addr !== 32'h214) $display("FAIL bne_not_taken: got %08h want 00000214", first_addr);
    else pass_cnt++;
    total_cnt++;
    if (req_cnt != 5 || ret_cnt != 0) $display("FAIL timeout_cycles: got req=%0d act=%0d want 5 0", req_cnt, ret_cnt);
    else pass_cnt++;
    total_cnt++;
    if (error !== 1'b1 || imem_req !== 1'b0) $display("FAIL timeout_trap: got err=%0b req=%0b want 1 0", error, imem_req);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total_cnt++;
    if (error !== 1'b0) $display("FAIL reset_clears_error: got %0b want 0", error);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200)
      $display("FAIL restart_pc: got req=%0b addr=%08h want 1 00000200", imem_req, imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_illegal_and_reset();
    int act_cnt = 0;
    issue(I_ILLEGAL);
    #1 act_cnt += int'(retire);
    repeat (4) begin
      @(negedge clk);
      #1 act_cnt += int'(retire) + int'(imem_req) + int'(dmem_req);
    end
    $display("illeg  error=%0b activity=%0d pc=%08h", error, act_cnt, imem_addr);
    total_cnt++;
    if (error !== 1'b1 || act_cnt != 0) $display("FAIL illegal_trap: got err=%0b act=%0d want 1 0", error, act_cnt);
    else pass_cnt++;
    total_cnt++;
    if (imem_addr !== 32'h200) $display("FAIL illegal_pc_frozen: got %08h want 00000200", imem_addr);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    issue(I_LW_X2_0_X1);
    @(negedge clk);
    #1;
    total_cnt++;
    if (dmem_req !== 1'b1) $display("FAIL mid_mem_req: got %0b want 1", dmem_req);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (dmem_req !== 1'b0 || retire !== 1'b0 || imem_req !== 1'b0)
      $display("FAIL reset_drops_dmem: got dreq=%0b ret=%0b req=%0b want 0 0 0", dmem_req, retire, imem_req);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200)
      $display("FAIL mid_mem_reset_pc: got req=%0b addr=%08h want 1 00000200", imem_req, imem_addr);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_load();
    test_store_byte();
    test_branch();
    test_timeout();
    test_illegal_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
